axi_ram_burst: RTL

AXI_RAM_BURST -- requirements
Module: axi_ram_burst

---
 rtl/axi_ram_burst.sv | 221 ++++++++++++++++++++++
 1 files changed

// File: rtl/axi_ram_burst.sv
// AXI4 burst-capable single-port-per-direction RAM slave: independent write and read FSMs,
// byte-lane strobes, FIXED/INCR/WRAP addressing and a prefetching read path.
package axi_ram_burst_pkg;
  localparam int ID_W   = 4;
  localparam int ID_R   = 4;
  localparam int ADDR_W = 16;
  localparam int DATA_W = 32;

  typedef struct packed {
    logic [ID_W-1:0]     awid;
    logic [ADDR_W-1:0]   awaddr;
    logic [7:0]          awlen;
    logic [2:0]          awsize;
    logic [1:0]          awburst;
    logic                awvalid;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wlast;
    logic                wvalid;
    logic                bready;
    logic [ID_R-1:0]     arid;
    logic [ADDR_W-1:0]   araddr;
    logic [7:0]          arlen;
    logic [2:0]          arsize;
    logic [1:0]          arburst;
    logic                arvalid;
    logic                rready;
  } axi_mosi_t;

  typedef struct packed {
    logic              awready;
    logic              wready;
    logic [ID_W-1:0]   bid;
    logic [1:0]        bresp;
    logic              bvalid;
    logic              arready;
    logic [ID_R-1:0]   rid;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        rresp;
    logic              rlast;
    logic              rvalid;
  } axi_miso_t;
endpackage

module axi_ram_burst
  import axi_ram_burst_pkg::*;
#(
  parameter int ID_W_WIDTH     = 4,
  parameter int ID_R_WIDTH     = 4,
  parameter int ADDR_WIDTH     = 16,
  parameter int AXI_DATA_WIDTH = 32,
  parameter int BYTE_WIDTH     = 8,
  parameter int MEM_DEPTH      = 1024
) (
  input  logic      clk_i,
  input  logic      rst_i,
  input  axi_mosi_t in_mosi_i,
  output axi_miso_t in_miso_o
);

  localparam int unsigned BYTES  = AXI_DATA_WIDTH / 8;
  localparam int unsigned LSB    = $clog2(BYTES);
  localparam int unsigned LANES  = AXI_DATA_WIDTH / BYTE_WIDTH;
  localparam int unsigned MIDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [1:0]  OKAY   = 2'b00;
  localparam logic [1:0]  SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_FETCH, R_DATA} r_state_t;

  // WRAP window mask is {len, byte-offset ones}; valid because legal wrap lengths are 2^n-1.
  function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] a,
                                                      input logic [7:0] len,
                                                      input logic [1:0] burst);
    logic [ADDR_WIDTH-1:0] mask;
    mask = (ADDR_WIDTH'(len) << LSB) | ADDR_WIDTH'(BYTES - 1);
    case (burst)
      2'd0:    next_addr = a;
      2'd2:    next_addr = (a & ~mask) | ((a + ADDR_WIDTH'(BYTES)) & mask);
      default: next_addr = a + ADDR_WIDTH'(BYTES);
    endcase
  endfunction

  function automatic logic burst_bad(input logic [2:0] size, input logic [7:0] len,
                                     input logic [1:0] burst);
    burst_bad = (size != 3'(LSB)) || (burst == 2'd3) ||
                ((burst == 2'd2) && !(len inside {8'd1, 8'd3, 8'd7, 8'd15}));
  endfunction

  function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
    in_range = (a >> LSB) < ADDR_WIDTH'(MEM_DEPTH);
  endfunction

  logic [AXI_DATA_WIDTH-1:0] mem [MEM_DEPTH];

  w_state_t                w_state, w_next;
  logic [ID_W_WIDTH-1:0]   w_id;
  logic [ADDR_WIDTH-1:0]   w_addr;
  logic [7:0]              w_len, w_cnt;
  logic [1:0]              w_burst;
  logic                    w_err, w_bad;
  logic                    aw_hs, w_hs, w_final;

  r_state_t                r_state, r_next;
  logic [ID_R_WIDTH-1:0]   r_id;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic [7:0]              r_len, r_cnt;
  logic [1:0]              r_burst;
  logic                    r_err, r_oor;
  logic [AXI_DATA_WIDTH-1:0] mem_q;
  logic                    ar_hs, r_hs, r_final, fetch_en;

  assign aw_hs    = in_mosi_i.awvalid && (w_state == W_IDLE);
  assign w_hs     = in_mosi_i.wvalid && (w_state == W_DATA);
  assign w_final  = (w_cnt == w_len);
  assign ar_hs    = in_mosi_i.arvalid && (r_state == R_IDLE);
  assign r_hs     = in_mosi_i.rready && (r_state == R_DATA);
  assign r_final  = (r_cnt == r_len);
  assign fetch_en = (r_state == R_FETCH) || (r_hs && !r_final);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      w_state <= W_IDLE;
      r_state <= R_IDLE;
    end else begin
      w_state <= w_next;
      r_state <= r_next;
    end
  end

  always_comb begin
    w_next = w_state;
    case (w_state)
      W_IDLE:  if (in_mosi_i.awvalid) w_next = W_DATA;
      W_DATA:  if (in_mosi_i.wvalid && w_final) w_next = W_RESP;
      W_RESP:  if (in_mosi_i.bready) w_next = W_IDLE;
      default: w_next = W_IDLE;
    endcase
  end

  always_comb begin
    r_next = r_state;
    case (r_state)
      R_IDLE:  if (in_mosi_i.arvalid) r_next = R_FETCH;
      R_FETCH: r_next = R_DATA;
      R_DATA:  if (in_mosi_i.rready && r_final) r_next = R_IDLE;
      default: r_next = R_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      w_cnt <= '0;
      w_err <= 1'b0;
      w_bad <= 1'b0;
      r_cnt <= '0;
      r_err <= 1'b0;
      r_oor <= 1'b0;
    end else begin
      if (aw_hs) begin
        w_id    <= in_mosi_i.awid;
        w_addr  <= in_mosi_i.awaddr;
        w_len   <= in_mosi_i.awlen;
        w_burst <= in_mosi_i.awburst;
        w_err   <= burst_bad(in_mosi_i.awsize, in_mosi_i.awlen, in_mosi_i.awburst);
        w_cnt   <= '0;
        w_bad   <= 1'b0;
      end
      if (w_hs) begin
        w_addr <= next_addr(w_addr, w_len, w_burst);
        w_cnt  <= w_cnt + 8'd1;
        if ((in_mosi_i.wlast != w_final) || !in_range(w_addr)) w_bad <= 1'b1;
      end
      if (ar_hs) begin
        r_id    <= in_mosi_i.arid;
        r_addr  <= in_mosi_i.araddr;
        r_len   <= in_mosi_i.arlen;
        r_burst <= in_mosi_i.arburst;
        r_err   <= burst_bad(in_mosi_i.arsize, in_mosi_i.arlen, in_mosi_i.arburst);
        r_cnt   <= '0;
      end
      // r_addr always points at the next word to fetch; r_oor tracks the word in mem_q.
      if (fetch_en) begin
        r_addr <= next_addr(r_addr, r_len, r_burst);
        r_oor  <= !in_range(r_addr);
      end
      if (r_hs) r_cnt <= r_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_hs && !rst_i && !w_err && in_range(w_addr)) begin
      for (int unsigned l = 0; l < LANES; l++) begin
        if (in_mosi_i.wstrb[l])
          mem[w_addr[LSB +: MIDX_W]][l*BYTE_WIDTH +: BYTE_WIDTH] <=
            in_mosi_i.wdata[l*BYTE_WIDTH +: BYTE_WIDTH];
      end
    end
    if (fetch_en) mem_q <= mem[r_addr[LSB +: MIDX_W]];
  end

  always_comb begin
    in_miso_o         = '0;
    in_miso_o.awready = (w_state == W_IDLE) && !rst_i;
    in_miso_o.wready  = (w_state == W_DATA);
    if (w_state == W_RESP) begin
      in_miso_o.bvalid = 1'b1;
      in_miso_o.bid    = w_id;
      in_miso_o.bresp  = (w_err || w_bad) ? SLVERR : OKAY;
    end
    in_miso_o.arready = (r_state == R_IDLE) && !rst_i;
    if (r_state == R_DATA) begin
      in_miso_o.rvalid = 1'b1;
      in_miso_o.rid    = r_id;
      in_miso_o.rlast  = r_final;
      if (r_err || r_oor) in_miso_o.rresp = SLVERR;
      else                in_miso_o.rdata = mem_q;
    end
  end

endmodule
